// File: rtl/mips_register_file.sv
// 32 x DATA_WIDTH MIPS register file: two combinational read ports, one write port, $zero hardwired to 0.
// Latency: reads 0 cycles, writes commit on the rising edge; no internal forwarding and no backpressure.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 has no storage at all, so $zero can never hold a nonzero value.
    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
    logic [DEPTH-1:1]      wr_sel;

    // Gating with reg_write keeps an unknown write_reg from selecting anything while idle.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_sel[i] = reg_write && (write_reg == ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // Reads see storage only, so a same-cycle write shows up after the edge.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (read_reg1 == ADDR_WIDTH'(i)) begin
                read_data1 = regs[i];
            end
            if (read_reg2 == ADDR_WIDTH'(i)) begin
                read_data2 = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed plus randomized bench for mips_register_file against an array-based register model.
module tb_mips_register_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [0:31];

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Architectural view: a write lands on the edge unless reset, disabled or aimed at $zero.
    task automatic step();
        @(posedge clk);
        if (reset !== 1'b1 && reg_write === 1'b1 && write_reg !== 5'd0)
            model[write_reg] = write_data;
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic write1(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1; write_reg = a; write_data = d;
        step();
        reg_write = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = 5'd0; read_reg2 = 5'd31;
        #2;
        check("reset_rd1_idx0", read_data1, 32'h0);
        check("reset_rd2_idx31", read_data2, 32'h0);
        step();
        #3 reset = 1'b0;
        step();

        // Preload, then an asynchronous reset pulse mid-cycle.
        write1(5'd5, 32'hDEADBEEF);
        read_reg1 = 5'd5;
        #1 check("preload_reg5", read_data1, 32'hDEADBEEF);
        #2 reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1 check("async_reset_reg5", read_data1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            check("reset_sweep_rd1", read_data1, 32'h0);
            check("reset_sweep_rd2", read_data2, 32'h0);
        end
        // Reset wins over a simultaneous write.
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h0BAD0BAD; read_reg1 = 5'd7;
        step();
        check("reset_blocks_write", read_data1, 32'h0);
        reg_write = 1'b0;
        #4 reset = 1'b0;
        #1 check("post_reset_hold", read_data1, 32'h0);
        step();

        // Basic write/read on both ports.
        write1(5'd8, 32'h12345678);
        write1(5'd9, 32'hABCD0000);
        read_reg1 = 5'd8; read_reg2 = 5'd9;
        #1;
        check("basic_rd1_reg8", read_data1, 32'h12345678);
        check("basic_rd2_reg9", read_data2, 32'hABCD0000);
        read_reg1 = 5'd9;
        #1;
        check("same_idx_rd1", read_data1, 32'hABCD0000);
        check("same_idx_rd2", read_data2, 32'hABCD0000);

        // $zero protection.
        write1(5'd0, 32'hFFFFFFFF);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1;
        check("zero_rd1", read_data1, 32'h0);
        check("zero_rd2", read_data2, 32'h0);

        // Write disabled across four edges.
        reg_write = 1'b0; write_reg = 5'd3; write_data = 32'h55AA55AA; read_reg1 = 5'd3;
        repeat (4) step();
        check("wr_disabled_reg3", read_data1, 32'h0);

        // Same-cycle read/write: old value before the edge, new after.
        write1(5'd10, 32'h1);
        read_reg1 = 5'd10; reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h2;
        #1 check("rw_before_edge", read_data1, 32'h1);
        step();
        check("rw_after_edge", read_data1, 32'h2);
        reg_write = 1'b0;

        // Full sweep with distinct per-index patterns.
        for (int i = 1; i < 32; i++) write1(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i);
            #1;
            check("sweep_rd1", read_data1, 32'(i) * 32'h01010101);
            check("sweep_rd2", read_data2, 32'(i) * 32'h01010101);
        end

        // Randomized traffic checked against the model before and after each edge.
        for (int n = 0; n < 400; n++) begin
            reg_write  = 1'($urandom_range(0, 1));
            write_reg  = 5'($urandom);
            write_data = ($urandom_range(0, 3) == 0) ? {16'($urandom), 16'h0} : $urandom;
            if (!reg_write && $urandom_range(0, 3) == 0) write_reg = 'x;
            ra = 5'($urandom);
            rb = 5'($urandom);
            if ($urandom_range(0, 3) == 0 && reg_write) ra = write_reg;
            if ($urandom_range(0, 3) == 0 && reg_write) rb = write_reg;
            read_reg1 = ra; read_reg2 = rb;
            #1;
            check("rand_pre_rd1", read_data1, ref_rd(ra));
            check("rand_pre_rd2", read_data2, ref_rd(rb));
            step();
            check("rand_post_rd1", read_data1, ref_rd(ra));
            check("rand_post_rd2", read_data2, ref_rd(rb));
        end
        reg_write = 1'b0; write_reg = '0;

        // Final full readback of the randomized state.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            check("final_rd1", read_data1, ref_rd(5'(i)));
            check("final_rd2", read_data2, ref_rd(5'(31 - i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
